// File: rtl/sdft_bin_scanner.sv
// Sweeps every bin of the sliding-DFT core through its read handshake, streams an
// alpha-max-beta-min magnitude per bin and reports the strongest bin at the end.
module sdft_bin_scanner #(
    parameter int freq_bins = 128,
    parameter int bin_width = 23,
    parameter bit skip_dc   = 1'b0,
    localparam int addr_w   = $clog2(freq_bins),
    localparam int mag_w    = bin_width + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan,
    output logic                 busy,
    output logic                 done,
    input  logic                 core_ready,
    output logic                 core_read,
    output logic [addr_w-1:0]    core_bin_addr,
    input  logic [bin_width-1:0] core_real,
    input  logic [bin_width-1:0] core_imag,
    output logic                 mag_valid,
    output logic [addr_w-1:0]    mag_addr,
    output logic [mag_w-1:0]     mag,
    output logic [addr_w-1:0]    peak_bin,
    output logic [mag_w-1:0]     peak_mag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LO,
        S_WAIT_HI,
        S_CALC,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [addr_w-1:0]      r_cnt;
    logic [bin_width-1:0]   r_re;
    logic [bin_width-1:0]   r_im;
    logic [mag_w-1:0]       r_mag;
    logic [addr_w-1:0]      r_mag_addr;
    logic                   r_mag_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_read;
    logic [addr_w-1:0]      r_peak_bin;
    logic [mag_w-1:0]       r_peak_mag;

    logic [bin_width-1:0]   w_abs_re;
    logic [bin_width-1:0]   w_abs_im;
    logic [bin_width-1:0]   w_max;
    logic [bin_width-1:0]   w_min_half;
    logic [mag_w-1:0]       w_mag;
    logic                   w_peak_upd;

    // Unsigned negation of the most negative value yields exactly 2^(bin_width-1).
    assign w_abs_re   = r_re[bin_width-1] ? -r_re : r_re;
    assign w_abs_im   = r_im[bin_width-1] ? -r_im : r_im;
    assign w_max      = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min_half = ((w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re) >> 1;
    assign w_mag      = {1'b0, w_max} + {1'b0, w_min_half};

    // Strict compare keeps the lowest index on ties.
    assign w_peak_upd = (r_mag > r_peak_mag) && !(skip_dc && (r_mag_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_mag       <= '0;
            r_mag_addr  <= '0;
            r_mag_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_read      <= 1'b0;
            r_peak_bin  <= '0;
            r_peak_mag  <= '0;
        end else begin
            r_mag_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (scan) begin
                        r_cnt      <= '0;
                        r_peak_bin <= '0;
                        r_peak_mag <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (core_ready) begin
                        r_read  <= 1'b1;
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!core_ready) begin
                        r_read  <= 1'b0;
                        r_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (core_ready) begin
                        r_re    <= core_real;
                        r_im    <= core_imag;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_mag       <= w_mag;
                    r_mag_addr  <= r_cnt;
                    r_mag_valid <= 1'b1;
                    r_state     <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_peak_upd) begin
                        r_peak_bin <= r_mag_addr;
                        r_peak_mag <= r_mag;
                    end
                    if (r_cnt == addr_w'(freq_bins - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + addr_w'(1);
                        r_state <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign core_read     = r_read;
    assign core_bin_addr = r_cnt;
    assign mag_valid     = r_mag_valid;
    assign mag_addr      = r_mag_addr;
    assign mag           = r_mag;
    assign peak_bin      = r_peak_bin;
    assign peak_mag      = r_peak_mag;

endmodule

// File: tb/tb_sdft_bin_scanner.sv
// Scoreboard bench: two scanners (skip_dc 0 and 1) share one handshaking core model.
module tb_sdft_bin_scanner;

    localparam int NB = 8;
    localparam int BW = 23;

    logic clk = 1'b0;
    logic reset;
    logic scan;
    logic core_ready;
    logic signed [BW-1:0] core_real, core_imag;

    logic          a_busy, a_done, a_core_read, a_mag_valid;
    logic [2:0]    a_core_bin_addr, a_mag_addr, a_peak_bin;
    logic [BW:0]   a_mag, a_peak_mag;
    logic          b_busy, b_done, b_core_read, b_mag_valid;
    logic [2:0]    b_core_bin_addr, b_mag_addr, b_peak_bin;
    logic [BW:0]   b_mag, b_peak_mag;

    logic signed [BW-1:0] mre [NB];
    logic signed [BW-1:0] mim [NB];

    typedef struct packed {
        logic [2:0]  a;
        logic [BW:0] m;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  prev_cyc = 0;
    int  lat = 3;
    int  rcnt = 0;
    bit  r_rdy = 1'b1;
    bit  hold = 1'b0;
    int  hold_cnt = 0;
    bit  stall_arm = 1'b0;
    bit  chk_sp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdft_bin_scanner #(.freq_bins(NB), .bin_width(BW), .skip_dc(1'b0)) dut_a (
        .clk(clk), .reset(reset), .scan(scan), .busy(a_busy), .done(a_done),
        .core_ready(core_ready), .core_read(a_core_read), .core_bin_addr(a_core_bin_addr),
        .core_real(core_real), .core_imag(core_imag), .mag_valid(a_mag_valid),
        .mag_addr(a_mag_addr), .mag(a_mag), .peak_bin(a_peak_bin), .peak_mag(a_peak_mag)
    );

    sdft_bin_scanner #(.freq_bins(NB), .bin_width(BW), .skip_dc(1'b1)) dut_b (
        .clk(clk), .reset(reset), .scan(scan), .busy(b_busy), .done(b_done),
        .core_ready(core_ready), .core_read(b_core_read), .core_bin_addr(b_core_bin_addr),
        .core_real(core_real), .core_imag(core_imag), .mag_valid(b_mag_valid),
        .mag_addr(b_mag_addr), .mag(b_mag), .peak_bin(b_peak_bin), .peak_mag(b_peak_mag)
    );

    // Core model: drops ready the edge after read, raises it lat cycles later.
    assign core_ready = r_rdy & ~hold;
    assign core_real  = mre[a_core_bin_addr];
    assign core_imag  = mim[a_core_bin_addr];

    always @(posedge clk) begin
        if (core_ready && a_core_read) begin
            r_rdy <= 1'b0;
            rcnt  <= lat - 1;
        end else if (!r_rdy) begin
            if (rcnt == 0) r_rdy <= 1'b1;
            else           rcnt  <= rcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW:0] ref_mag(input logic signed [BW-1:0] re, input logic signed [BW-1:0] im);
        int a, b, mx, mn;
        a  = (re < 0) ? -int'(re) : int'(re);
        b  = (im < 0) ? -int'(im) : int'(im);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return (BW+1)'(mx + mn / 2);
    endfunction

    task automatic ref_peak(input bit skip, output int pb, output int pm);
        int m;
        pb = 0;
        pm = 0;
        for (int i = 0; i < NB; i++) begin
            m = int'(ref_mag(mre[i], mim[i]));
            if (!(skip && i == 0) && m > pm) begin
                pb = i;
                pm = m;
            end
        end
    endtask

    task automatic clr_mem();
        for (int i = 0; i < NB; i++) begin
            mre[i] = '0;
            mim[i] = '0;
        end
    endtask

    task automatic push_exp();
        exp_t t;
        for (int i = 0; i < NB; i++) begin
            t.a = 3'(i);
            t.m = ref_mag(mre[i], mim[i]);
            sb.push_back(t);
        end
    endtask

    task automatic chk_zero();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_read", a_core_read, 0);
        chk("rst_mag_valid", a_mag_valid, 0);
        chk("rst_bin_addr", a_core_bin_addr, 0);
        chk("rst_mag_addr", a_mag_addr, 0);
        chk("rst_mag", a_mag, 0);
        chk("rst_peak_bin", a_peak_bin, 0);
        chk("rst_peak_mag", a_peak_mag, 0);
    endtask

    // Returns on the negedge of the done cycle, so a following call scans right after done.
    task automatic sweep(input bit mid, input bit in_done);
        bit got;
        int pb, pm;
        push_exp();
        @(negedge clk);
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        chk("busy_start", a_busy, 1);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (mid && k == 15)      scan = 1'b1;
            else if (mid && k == 16) scan = 1'b0;
            if (a_done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("sb_empty", sb.size(), 0);
        ref_peak(1'b0, pb, pm);
        chk("peak_bin_a", a_peak_bin, pb);
        chk("peak_mag_a", a_peak_mag, pm);
        ref_peak(1'b1, pb, pm);
        chk("peak_bin_b", b_peak_bin, pb);
        chk("peak_mag_b", b_peak_mag, pm);
        if (in_done) begin
            scan = 1'b1;
            @(negedge clk);
            scan = 1'b0;
            chk("busy_after_done", a_busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (a_mag_valid) begin
            if (sb.size() == 0) begin
                chk("extra_mag_valid", a_mag_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("mag_addr", a_mag_addr, mon_e.a);
                chk("mag", a_mag, mon_e.m);
            end
            if (chk_sp && a_mag_addr != 0) chk("spacing", cyc - prev_cyc, 8);
            prev_cyc = cyc;
            if (stall_arm && a_mag_addr == 3'd3) begin
                hold      = 1'b1;
                hold_cnt  = 10;
                stall_arm = 1'b0;
            end
        end else if (hold) begin
            chk("read_in_stall", a_core_read, 0);
            hold_cnt--;
            if (hold_cnt == 0) hold = 1'b0;
        end
        if (a_done) chk("done_latency", cyc - prev_cyc, 1);
    end

    initial begin
        bit seen;
        int pb, pm;
        reset = 1'b1;
        scan  = 1'b0;
        clr_mem();
        repeat (3) @(negedge clk);
        chk_zero();
        reset = 1'b0;

        chk_sp = 1'b1;
        sweep(1'b0, 1'b0);

        mre[3] = -23'sd300;
        mim[3] = 23'sd100;
        sweep(1'b0, 1'b0);

        mre[3] = -23'sd4194304;
        mim[3] = -23'sd4194304;
        sweep(1'b0, 1'b0);

        clr_mem();
        mre[2] = 23'sd50;
        mre[6] = 23'sd50;
        sweep(1'b0, 1'b0);
        mre[0] = 23'sd1000;
        sweep(1'b0, 1'b0);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NB; i++) begin
                mre[i] = BW'($urandom);
                mim[i] = BW'($urandom);
            end
            sweep(1'b0, 1'b0);
        end

        chk_sp    = 1'b0;
        stall_arm = 1'b1;
        sweep(1'b0, 1'b0);
        chk("stall_released", hold, 0);
        chk_sp = 1'b1;

        // Reset while waiting for ready to return on bin 5.
        push_exp();
        @(negedge clk);
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (a_mag_valid && a_mag_addr == 3'd4) seen = 1'b1;
        end
        chk("bin4_seen", seen, 1);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (a_core_read) seen = 1'b1;
        end
        chk("bin5_read", seen, 1);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (!a_core_read) seen = 1'b1;
        end
        chk("bin5_wait_hi", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero();
        sb.delete();
        repeat (30) @(negedge clk);
        chk("idle_after_reset", a_busy, 0);

        sweep(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("no_queued_sweep", a_busy, 0);
        ref_peak(1'b0, pb, pm);
        chk("peak_bin_hold", a_peak_bin, pb);
        chk("peak_mag_hold", a_peak_mag, pm);

        mre[5] = 23'sd4194303;
        mim[5] = -23'sd4194304;
        sweep(1'b0, 1'b0);
        sweep(1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdft_bin_scanner.md
# sdft_bin_scanner

Downstream consumer of the sliding-DFT core. On a scan request it walks every frequency bin through the core's read port, converts each complex bin to an approximate magnitude, streams the magnitudes out with their bin index, and reports the peak bin when the sweep ends. It feeds the display and pitch-detect logic, and lets them work without knowing the core's read protocol.

## Interface
- `freq_bins`, 128: number of bins in the core; power of two, ≥ 2.
- `bin_width`, 23: width of the core's real and imaginary outputs, two's complement.
- `skip_dc`, 0: when 1, bin 0 is still streamed but is excluded from the peak search.
- Derived: `addr_w = $clog2(freq_bins)`, `mag_w = bin_width + 1`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `scan`  in  1  start-sweep request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `scan` until DONE exits; the sample feeder must not pulse the core's `start` while this is high.
- `done`  out  1  one-cycle pulse; `peak_bin` and `peak_mag` are final in this cycle.
- `core_ready`  in  1  core's `ready`.
- `core_read`  out  1  core's `read`.
- `core_bin_addr`  out  addr_w  core's `bin_addr`.
- `core_real`  in  bin_width  core's `bin_out_real`.
- `core_imag`  in  bin_width  core's `bin_out_imag`.
- `mag_valid`  out  1  one-cycle strobe; `mag_addr` and `mag` are valid in this cycle.
- `mag_addr`  out  addr_w  bin index of `mag`.
- `mag`  out  mag_w  unsigned magnitude estimate.
- `peak_bin`  out  addr_w  index of the largest magnitude.
- `peak_mag`  out  mag_w  largest magnitude.

## Operation
- States:
  - IDLE: `busy` is 0.
    - `scan`=1 → clear the bin counter and the peak registers, go to REQ.
  - REQ: `core_bin_addr` = counter.
    - If `core_ready`=1, drive `core_read`=1 and go to WAIT_LO.
    - Otherwise stay in REQ.
  - WAIT_LO: hold `core_read`=1 and the address.
    - `core_ready`=0 → drop `core_read` and go to WAIT_HI.
  - WAIT_HI:
    - `core_ready`=1 → register `core_real` and `core_imag`, go to CALC.
  - CALC: compute the magnitude and register it into `mag` and `mag_addr`.
    - `mag_valid` is asserted in the next cycle, which is the NEXT state.
  - NEXT: `mag_valid`=1. Update the peak.
    - If counter = `freq_bins`−1 → DONE.
    - Otherwise increment the counter and go to REQ.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Magnitude rule (alpha-max-beta-min, alpha=1, beta=1/2):
  - `a` = |re| and `b` = |im|, each held in bin_width bits unsigned. |−2^(bin_width−1)| = 2^(bin_width−1) is exact; no saturation.
  - `mag` = max(a,b) + (min(a,b) >> 1), zero-extended to mag_w. It cannot overflow.
- Peak rule:
  - Replace the peak only when `mag` > `peak_mag` (strictly greater), so on a tie the lower index wins.
  - With `skip_dc`=1, bin 0 never updates the peak.
  - If every candidate magnitude is 0, the result is `peak_bin`=0 and `peak_mag`=0.
- `peak_bin` and `peak_mag` hold their value after DONE until the next accepted `scan`.
- `scan` asserted while `busy` is ignored. No sweep is queued.
- Counter wrap: the counter never increments past `freq_bins`−1. After DONE it is cleared by the next `scan`.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `core_read`, `mag_valid` = 0.
  - `core_bin_addr`, `mag_addr`, `mag`, `peak_bin`, `peak_mag` = 0.
- Reset during a sweep takes effect at the next edge: IDLE is entered and `core_read` is released. The core's own read cycle completes unobserved.
- Per-bin latency with a core that drops `ready` on the edge after `read` and raises it N cycles later:
  - N + 4 cycles from REQ entry to `mag_valid`.
  - Consecutive bins are N + 5 cycles apart.
- `core_read` is never high while `core_ready` has been observed low in the same state. Read asserts only from REQ with `core_ready`=1.
- `done` fires exactly one cycle after the `mag_valid` of bin `freq_bins`−1.
- A core that is busy with a sample (`ready`=0) when the scanner enters REQ only stalls REQ. There is no timeout.

## Test plan
- Reset mid-sweep: `reset` in WAIT_HI of bin 5 → next cycle IDLE; all outputs 0; `core_read`=0.
- All-zero core, `freq_bins`=8: 8 `mag_valid` strobes, addr 0..7, `mag`=0; `done` → `peak_bin`=0, `peak_mag`=0.
- Arithmetic, bin 3 (re=−300, im=100):
  - `mag`=350; with all other bins 0 → `peak_bin`=3, `peak_mag`=350.
  - re=−4194304, im=−4194304 → `mag`=6291456 (24-bit, no wrap).
- Tie and DC:
  - bins 2 and 6 both re=50, im=0 → `peak_bin`=2.
  - Bin 0 re=1000 with `skip_dc`=1 → `peak_bin`=2; with `skip_dc`=0 → `peak_bin`=0.
- Handshake stall:
  - Core model holds `ready` low for 10 cycles before bin 4 → scanner stays in REQ with `core_read`=0; then completes normally.
  - Spacing with ready-latency N=3 is 8 cycles.
- `scan` pulsed during a sweep and again in the `done` cycle → ignored both times; one sweep only. A `scan` one cycle after `done` starts a new sweep.
